// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared definitions for the instruction-memory boot loader
package cpu_defs;

    localparam int INSTR_WIDTH = 32;
    localparam int LEN_BYTES   = 2;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in, instruction memory write port out
interface imem_loader_if
    import cpu_defs::*;
#(
    parameter int ADDR_WIDTH = 10
);

    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   rx_ready;
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [INSTR_WIDTH-1:0] mem_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_loader_byte_assembler.sv
// rtl/imem_loader_byte_assembler.sv - big-endian 4-byte word shift register
module byte_assembler
    import cpu_defs::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   shift_en,
    input  logic                   clr,
    input  logic [7:0]             rx_data,
    output logic [INSTR_WIDTH-1:0] word,
    output logic                   word_full
);

    logic [INSTR_WIDTH-1:0] asm_q;
    logic [1:0]             cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            asm_q <= '0;
            cnt_q <= '0;
        end else if (shift_en) begin
            asm_q <= {asm_q[INSTR_WIDTH-9:0], rx_data};
            cnt_q <= cnt_q + 2'd1;
        end
    end

    // high while the next shift completes a word; the counter wraps on that shift
    assign word_full = (cnt_q == 2'd3);
    assign word      = asm_q;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to instruction memory, holds CPU in reset until loaded
module imem_loader
    import cpu_defs::*;
#(
    parameter int ADDR_WIDTH = 10
)(
    input  logic              clk,
    input  logic              reset,
    imem_loader_if.slave      bus,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_WIDTH:0] words_loaded
);

    localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

    loader_state_t          state, state_nx;
    logic [15:0]            len;
    logic [15:0]            len_full;
    logic [ADDR_WIDTH:0]    word_idx;
    logic [ADDR_WIDTH:0]    idx_nx;
    logic                   rx_ready;
    logic                   xfer;
    logic                   shift_en;
    logic                   asm_clr;
    logic                   word_full;
    logic [INSTR_WIDTH-1:0] word;

    assign rx_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
    assign xfer     = bus.rx_valid && rx_ready;
    assign shift_en = xfer && (state == DATA);
    assign asm_clr  = xfer && (state == LEN_LO);
    assign len_full = {len[15:8], bus.rx_data};
    assign idx_nx   = word_idx + (ADDR_WIDTH+1)'(1);

    byte_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (shift_en),
        .clr       (asm_clr),
        .rx_data   (bus.rx_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LEN_HI;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            LEN_HI: if (xfer) state_nx = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (len_full == 16'd0)
                        state_nx = DONE;
                    else if ({1'b0, len_full} > DEPTH)
                        state_nx = ERR;
                    else
                        state_nx = DATA;
                end
            end
            DATA:   if (xfer && word_full) state_nx = WRITE;
            WRITE:  state_nx = (17'(idx_nx) == {1'b0, len}) ? DONE : DATA;
            DONE:   state_nx = DONE;
            ERR:    state_nx = ERR;
            default: state_nx = LEN_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len      <= '0;
            word_idx <= '0;
        end else begin
            if (xfer && state == LEN_HI) len[15:8] <= bus.rx_data;
            if (xfer && state == LEN_LO) len       <= len_full;
            if (state == WRITE)          word_idx  <= idx_nx;
        end
    end

    // every output is a decode of state or a register, never of rx_*
    assign bus.rx_ready  = rx_ready;
    assign bus.mem_we    = (state == WRITE);
    assign bus.mem_addr  = word_idx[ADDR_WIDTH-1:0];
    assign bus.mem_wdata = word;
    assign cpu_reset     = (state != DONE);
    assign done          = (state == DONE);
    assign error         = (state == ERR);
    assign words_loaded  = word_idx;

endmodule
